// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   tx_state_e       : FSM encodings (IDLE=0, SEND=1, WAIT=2)
//   DEF_DEPTH        : default FIFO depth in bytes
//   DEF_FRAME_CYCLES : default clk cycles reserved per UART frame
//   UART_ADDR        : store address decoded upstream into wr_en
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  localparam int          DEF_DEPTH        = 16;
  localparam int          DEF_FRAME_CYCLES = 8680;
  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;

  // Timer width: it only ever holds FRAME_CYCLES-3, so clog2(FRAME_CYCLES) bits suffice.
  function automatic int timer_w(input int frame_cycles);
    return $clog2(frame_cycles);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_byte_fifo.sv
// byte_fifo: byte FIFO with registered level/full/empty.
//   clk, rst : clock, synchronous active-high reset
//   push/din : enqueue din (ignored while full)
//   pop/dout : dequeue; dout is the current head (combinational read)
//   level    : bytes held, 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  // Flags come from registered level only, so a same-cycle push cannot
  // change what the producer sees this cycle.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally; level tells full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers CPU stores to the UART and paces them out one
// byte per FRAME_CYCLES.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : UART store in MA stage and its byte
//   full              : FIFO full; CPU stalls the store
//   uart_wr, uart_dat : one-cycle transmit strobe and byte to the uart module
//   level             : bytes buffered
//   drop_cnt          : saturating count of writes rejected while full
//   idle              : FSM idle and nothing buffered
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   uart_wr,
  output logic [7:0]             uart_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt,
  output logic                   idle
);
  localparam int            TW         = timer_w(FRAME_CYCLES);
  // SEND (1) + WAIT (FRAME_CYCLES-2) + IDLE (1) = FRAME_CYCLES between strobes.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 3);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          uart_wr_q, uart_wr_d;
  logic [7:0]    uart_dat_q, uart_dat_d;
  logic [7:0]    drop_q, drop_d;
  logic          fifo_pop, fifo_empty;
  logic [7:0]    fifo_dout;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Pop on the edge that enters SEND so the strobe is registered.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          uart_dat_d = fifo_dout;
          uart_wr_d  = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_d = TIMER_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write while full is lost even if a pop frees a slot at the same edge.
  always_comb begin
    drop_d = drop_q;
    if (wr_en && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
      drop_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      drop_q     <= drop_d;
    end
  end

  assign uart_wr  = uart_wr_q;
  assign uart_dat = uart_dat_q;
  assign drop_cnt = drop_q;
  assign idle     = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int FC    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, uart_wr, idle;
  logic [7:0] uart_dat, drop_cnt;
  logic [$clog2(DEPTH):0] level;

  uart_tx_scheduler #(.DEPTH(DEPTH), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .uart_wr(uart_wr), .uart_dat(uart_dat), .level(level),
    .drop_cnt(drop_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q[$];
  int         strb_q[$];
  bit         sat_mode = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Inputs are set at a negedge; returns at the negedge after the next posedge.
  task automatic drive(input logic we, input logic [7:0] d);
    wr_en = we; wr_data = d;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  // Monitor: every strobe is matched against the scoreboard.
  initial begin
    logic prev_wr;
    logic [7:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_wr === 1'b1 && rst === 1'b0) begin
        strb_q.push_back(cyc);
        chk("strobe_width", int'(prev_wr), 0);
        if (sat_mode) begin
          chk("sat_data", int'(uart_dat), 8'h7E);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_strobe", int'(uart_dat), -1);
        end else begin
          e = exp_q.pop_front();
          chk("uart_dat", int'(uart_dat), int'(e));
        end
      end
      prev_wr = uart_wr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nf, budget;
    logic full_now;

    // Reset with a write presented: write must be ignored.
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk); @(negedge clk);
    chk("rst_uart_wr", int'(uart_wr), 0);
    chk("rst_uart_dat", int'(uart_dat), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    idle_cycles(2);

    // Single byte latency and idle return.
    strb_q.delete();
    exp_q.push_back(8'h41);
    drive(1'b1, 8'h41); k = cyc;
    chk("single_level", int'(level), 1);
    chk("single_wr_early", int'(uart_wr), 0);
    chk("single_idle_busy", int'(idle), 0);
    drive(1'b0, 8'h00);
    chk("single_wr_high", int'(uart_wr), 1);
    chk("single_level_pop", int'(level), 0);
    drive(1'b0, 8'h00);
    chk("single_wr_low", int'(uart_wr), 0);
    idle_cycles(5);
    chk("single_idle_wait", int'(idle), 0);
    drive(1'b0, 8'h00);
    chk("single_idle_back", int'(idle), 1);
    chk("single_strobes", strb_q.size(), 1);
    chk("single_strobe_cyc", strb_q[0], k + 1);

    // Burst of four: order, 8-cycle spacing, level peak 3.
    idle_cycles(3);
    strb_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    drive(1'b1, 8'h01); k = cyc;
    drive(1'b1, 8'h02);
    chk("burst_level_k1", int'(level), 1);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    chk("burst_level_peak", int'(level), 3);
    idle_cycles(40);
    chk("burst_strobes", strb_q.size(), 4);
    chk("burst_first_cyc", strb_q[0], k + 1);
    for (int i = 1; i < 4; i++) chk("burst_gap", strb_q[i] - strb_q[i-1], FC);
    chk("burst_drained", exp_q.size(), 0);

    // Overflow: six writes while busy, last two dropped.
    exp_q.push_back(8'h10);
    drive(1'b1, 8'h10);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h20 + i));
      drive(1'b1, 8'(8'h20 + i));
      if (i == 2) chk("ovf_not_full", int'(full), 0);
      if (i == 3) begin
        chk("ovf_full", int'(full), 1);
        chk("ovf_level", int'(level), 4);
      end
    end
    chk("ovf_drop", int'(drop_cnt), 2);
    idle_cycles(45);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_idle", int'(idle), 1);

    // Push on the popping edge with level 2 and FSM idle.
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    drive(1'b1, 8'h30);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h31);
    drive(1'b1, 8'h32);
    idle_cycles(5);
    chk("sim_level_pre", int'(level), 2);
    drive(1'b1, 8'h33);
    chk("sim_level_post", int'(level), 2);
    chk("sim_wr", int'(uart_wr), 1);
    idle_cycles(30);
    chk("sim_drained", exp_q.size(), 0);

    // Reset mid-WAIT with three bytes buffered.
    exp_q.push_back(8'h50);
    drive(1'b1, 8'h50);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h51);
    drive(1'b1, 8'h52);
    drive(1'b1, 8'h53);
    chk("rw_level_pre", int'(level), 3);
    rst = 1'b1;
    drive(1'b1, 8'h99);
    chk("rw_uart_wr", int'(uart_wr), 0);
    chk("rw_level", int'(level), 0);
    chk("rw_idle", int'(idle), 1);
    chk("rw_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    idle_cycles(24);
    chk("rw_level_after", int'(level), 0);

    // drop_cnt saturation: 300 writes presented while full.
    sat_mode = 1'b1;
    nf = 0; budget = 4000;
    while (nf < 300 && budget > 0) begin
      full_now = full;
      drive(1'b1, 8'h7E);
      if (full_now) nf++;
      budget--;
    end
    chk("sat_pushes", nf, 300);
    chk("sat_drop", int'(drop_cnt), 255);
    nf = 0; budget = 200;
    while (nf < 20 && budget > 0) begin
      full_now = full;
      drive(1'b1, 8'h7E);
      if (full_now) nf++;
      budget--;
    end
    chk("sat_hold", int'(drop_cnt), 255);
    rst = 1'b1;
    drive(1'b0, 8'h00);
    rst = 1'b0;
    sat_mode = 1'b0;
    chk("sat_rst_drop", int'(drop_cnt), 0);
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
